hard_mem_1rw_byte_mask_banked_wrapper: RTL and testbench
========================================================

// Module: hard_mem_1rw_byte_mask_banked_wrapper
// PURPOSE
//  Generalised single-port, byte-masked SRAM wrapper: parametrised width, depth, byte size and
//  bank count, with a valid/ready request interface and a valid-qualified read response.
//  A sequencer clears every entry after reset.
//  Sits under BlackParrot cache/tag arrays as the next generation of the fixed d512/w64 wrapper;
//  the internal storage is the synthesizable model (hard macro per bank when substituted).
// PARAMETERS
//  width_p       64    data word width in bits; must be a multiple of byte_width_p
//  els_p         512   total words; must be a multiple of banks_p
//  byte_width_p  8     bits covered by one write-mask bit
//  banks_p       1     number of banks, power of 2 (1,2,4,8)
//  init_val_p    '0    word value written to every entry by the init sequencer
//  addr_width_lp $clog2(els_p); mask_width_lp = width_p/byte_width_p (derived, do not override)
// PORTS
//  clk_i         in   1              clock, all state on posedge
//  reset_n_i     in   1              asynchronous, active-low reset
//  v_i           in   1              request valid
//  w_i           in   1              1 = write, 0 = read
//  addr_i        in   addr_width_lp  word address
//  data_i        in   width_p        write data
//  write_mask_i  in   mask_width_lp  byte enables, bit k covers data_i[k*byte_width_p +: byte_width_p]
//  ready_o       out  1              request accepted when v_i & ready_o
//  v_o           out  1              read response valid (1-cycle pulse per accepted read)
//  data_o        out  width_p        read data
//  init_done_o   out  1              1 once the init sweep has completed
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (reset_n_i); release is sampled on clk_i.
//  - Reset values: ready_o=0, v_o=0, data_o=0, init_done_o=0, FSM=INIT, init counter=0.
//  - FSM INIT: each cycle writes init_val_p to row init_cnt of ALL banks in parallel.
//    Counter runs 0..els_p/banks_p-1; after last row -> READY. Init takes exactly els_p/banks_p cycles.
//  - FSM READY: ready_o=1 every cycle, init_done_o=1; no return to INIT except by reset.
//  - v_i while ready_o=0 is ignored (no memory access, no response); requester must hold/retry.
//  - Bank select = addr_i[$clog2(banks_p)-1:0]; row = addr_i >> $clog2(banks_p).
//    Only the selected bank is enabled. banks_p=1 -> no select bits.
//  - Write (v_i&ready_o&w_i): bytes with write_mask_i[k]=1 updated at the edge, others unchanged.
//    Mask all-zero = no change. No response: v_o stays 0.
//  - Read (v_i&ready_o&~w_i): v_o=1 and data_o=mem[addr] in the next cycle (latency 1).
//    Back-to-back reads give one response per cycle, in order.
//  - data_o holds the last read value until the next read response; writes never disturb data_o,
//    even to the same address.
//  - Write then read of the same address on consecutive cycles returns the new data.
//  - addr_i >= els_p (non-power-of-2 els_p only): write dropped; read gives v_o=1, data_o=0.
//  - Reset asserted mid-operation: outputs to reset values immediately.
//    In-flight read response is discarded; INIT sweep restarts from row 0 after release.
// CONFIGURATION
//  HARD_MEM_OUT_REG_EN defined: adds an output register stage. Read latency 2; v_o delayed with
//    data_o; ready_o remains 1 every READY cycle (fully pipelined); reset clears both stages.
//  Undefined: read latency 1 as above, no extra flops.
// TESTING
//  - Init: width_p=64, els_p=512, banks_p=4, init_val_p=64'hA5.
//    Release reset -> ready_o rises after exactly 128 cycles; reading addr 0,1,510,511 returns 64'hA5.
//  - Masked write: write 64'h1122334455667788 mask 8'hFF to addr 5, then 64'hFFFF_FFFF_FFFF_FFFF
//    mask 8'h0F -> read addr 5 = 64'h11223344FFFFFFFF.
//  - Bank isolation: banks_p=4; write distinct values to addr 4,5,6,7 -> each reads back its own value.
//  - Streaming: 16 back-to-back reads addr 0..15 -> 16 consecutive v_o pulses, in order.
//    Latency 1, or 2 with HARD_MEM_OUT_REG_EN.
//  - Gating: v_i=1 during INIT -> no v_o, contents still init_val_p; write at cycle after ready_o rises lands.
//  - Mid-op reset: assert reset_n_i=0 one cycle after a read is accepted -> v_o never pulses, data_o=0;
//    after release, full INIT re-runs and prior writes read back as init_val_p.

Source files
------------

// File: rtl/hard_mem_1rw_byte_mask_banked_wrapper.sv
// Single-port byte-masked banked SRAM wrapper with valid/ready requests and a post-reset init sweep.
// Optional HARD_MEM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module hard_mem_1rw_byte_mask_banked_wrapper #(
  parameter int unsigned          width_p       = 64,
  parameter int unsigned          els_p         = 512,
  parameter int unsigned          byte_width_p  = 8,
  parameter int unsigned          banks_p       = 1,
  parameter logic [width_p-1:0]   init_val_p    = '0,
  localparam int unsigned         addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned         mask_width_lp = width_p / byte_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     init_done_o
);

  localparam int unsigned bank_bits_lp = (banks_p > 1) ? $clog2(banks_p) : 0;
  localparam int unsigned sel_width_lp = (bank_bits_lp > 0) ? bank_bits_lp : 1;
  localparam int unsigned rows_lp      = els_p / banks_p;
  localparam int unsigned row_width_lp = (rows_lp > 1) ? $clog2(rows_lp) : 1;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  state_e                  r_state, w_state_next;
  logic [row_width_lp-1:0] r_init_cnt, w_init_cnt_next;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    case (r_state)
      StInit: begin
        w_init_cnt_next = r_init_cnt + row_width_lp'(1);
        if (r_init_cnt == row_width_lp'(rows_lp - 1)) begin
          w_state_next    = StReady;
          w_init_cnt_next = '0;
        end
      end
      StReady: w_state_next = StReady;
      default: w_state_next = StInit;
    endcase
  end

  logic w_ready;
  logic w_init;
  assign w_ready     = (r_state == StReady);
  assign w_init      = (r_state == StInit);
  assign ready_o     = w_ready;
  assign init_done_o = w_ready;

  // Address decode: low bits pick the bank, the rest pick the row.
  logic [sel_width_lp-1:0] w_bank_sel;
  logic [row_width_lp-1:0] w_row;
  logic                    w_oob;

  if (bank_bits_lp > 0) begin : g_sel
    assign w_bank_sel = addr_i[sel_width_lp-1:0];
    assign w_row      = addr_i[bank_bits_lp +: row_width_lp];
  end else begin : g_nosel
    assign w_bank_sel = '0;
    assign w_row      = addr_i[row_width_lp-1:0];
  end

  assign w_oob = (32'(addr_i) >= els_p);

  logic w_fire, w_wr_fire, w_rd_fire;
  assign w_fire    = v_i & w_ready;
  assign w_wr_fire = w_fire & w_i & ~w_oob;
  assign w_rd_fire = w_fire & ~w_i;

  // During init every bank is written in parallel with a full mask.
  logic [banks_p-1:0]       w_bank_we;
  logic [row_width_lp-1:0]  w_mem_row;
  logic [width_p-1:0]       w_mem_data;
  logic [mask_width_lp-1:0] w_mem_mask;

  always_comb begin
    w_bank_we  = '0;
    w_mem_row  = w_row;
    w_mem_data = data_i;
    w_mem_mask = write_mask_i;
    if (w_init) begin
      w_bank_we  = '1;
      w_mem_row  = r_init_cnt;
      w_mem_data = init_val_p;
      w_mem_mask = '1;
    end else begin
      for (int b = 0; b < int'(banks_p); b++) begin
        w_bank_we[b] = w_wr_fire && (w_bank_sel == sel_width_lp'(b));
      end
    end
  end

  logic [width_p-1:0] w_bank_rdata [banks_p];

  for (genvar b = 0; b < int'(banks_p); b++) begin : g_bank
    logic [width_p-1:0] r_mem [rows_lp];

    always_ff @(posedge clk_i) begin
      if (w_bank_we[b]) begin
        for (int k = 0; k < int'(mask_width_lp); k++) begin
          if (w_mem_mask[k]) begin
            r_mem[w_mem_row][k*byte_width_p +: byte_width_p] <=
              w_mem_data[k*byte_width_p +: byte_width_p];
          end
        end
      end
    end

    assign w_bank_rdata[b] = r_mem[w_row];
  end

  logic               r_rd_v;
  logic [width_p-1:0] r_rd_data;

  // Read data register only loads on a read, so writes never disturb data_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_v <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_oob ? '0 : w_bank_rdata[w_bank_sel];
      end
    end
  end

`ifdef HARD_MEM_OUT_REG_EN
  logic               r_out_v;
  logic [width_p-1:0] r_out_data;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_v <= r_rd_v;
      if (r_rd_v) begin
        r_out_data <= r_rd_data;
      end
    end
  end

  assign v_o    = r_out_v;
  assign data_o = r_out_data;
`else
  assign v_o    = r_rd_v;
  assign data_o = r_rd_data;
`endif

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_banked_wrapper.sv
// Directed bench for hard_mem_1rw_byte_mask_banked_wrapper (64b x 512, 4 banks, init 'hA5).
module tb_hard_mem_1rw_byte_mask_banked_wrapper;

`ifdef HARD_MEM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam logic [63:0] InitVal = 64'hA5;

  logic        clk;
  logic        reset_n;
  logic        v_i;
  logic        w_i;
  logic [8:0]  addr_i;
  logic [63:0] data_i;
  logic [7:0]  mask_i;
  logic        ready_o;
  logic        v_o;
  logic [63:0] data_o;
  logic        init_done_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model [512];

  hard_mem_1rw_byte_mask_banked_wrapper #(
    .width_p      (64),
    .els_p        (512),
    .byte_width_p (8),
    .banks_p      (4),
    .init_val_p   (InitVal)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .v_i          (v_i),
    .w_i          (w_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .write_mask_i (mask_i),
    .ready_o      (ready_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .init_done_o  (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 512; i++) model[i] = InitVal;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; mask_i = m;
    @(posedge clk); #1;
    v_i = 1'b0;
    for (int k = 0; k < 8; k++) if (m[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic do_read(input logic [8:0] a, output logic v, output logic [63:0] d);
    v_i = 1'b1; w_i = 1'b0; addr_i = a;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (Lat - 1) begin
      @(posedge clk); #1;
    end
    v = v_o;
    d = data_o;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    n_checks++; if (v_o !== 1'b0) begin n_errors++; $display("FAIL reset_v got %b want 0", v_o); end
    n_checks++; if (data_o !== 64'h0) begin n_errors++; $display("FAIL reset_data got %h want 0", data_o); end
    n_checks++; if (init_done_o !== 1'b0) begin n_errors++; $display("FAIL reset_init_done got %b want 0", init_done_o); end
  endtask

  // Requests are hammered during init; none may take effect or respond.
  task automatic test_init_gating();
    logic        v;
    logic [63:0] d;
    int          cycles = 0;
    int          pulses = 0;
    logic [8:0]  addrs [4];
    addrs[0] = 9'd0; addrs[1] = 9'd1; addrs[2] = 9'd510; addrs[3] = 9'd511;
    model_reset();
    reset_n = 1'b1;
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd0; data_i = 64'hDEAD; mask_i = 8'hFF;
    while (cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (v_o) pulses++;
      if (ready_o) break;
      w_i = cycles[0];
    end
    n_checks++; if (cycles !== 128) begin n_errors++; $display("FAIL init_cycles got %0d want 128", cycles); end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL init_no_resp got %0d pulses want 0", pulses); end
    n_checks++; if (init_done_o !== 1'b1) begin n_errors++; $display("FAIL init_done got %b want 1", init_done_o); end
    do_write(9'd3, 64'h3333, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], v, d);
      n_checks++;
      if (v !== 1'b1 || d !== InitVal) begin
        n_errors++; $display("FAIL init_read[%0d] got v=%b %h want v=1 %h", addrs[i], v, d, InitVal);
      end
    end
    do_read(9'd3, v, d);
    n_checks++; if (d !== 64'h3333) begin n_errors++; $display("FAIL first_ready_write got %h want 3333", d); end
  endtask

  task automatic test_masked_write();
    logic        v;
    logic [63:0] d;
    do_write(9'd5, 64'h1122334455667788, 8'hFF);
    do_write(9'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_write(9'd5, 64'h0, 8'h00);
    do_read(9'd5, v, d);
    n_checks++;
    if (d !== 64'h11223344FFFFFFFF) begin
      n_errors++; $display("FAIL masked_write got %h want 11223344ffffffff", d);
    end
  endtask

  task automatic test_bank_isolation();
    logic        v;
    logic [63:0] d;
    logic [63:0] vals [4];
    vals[0] = 64'h4444_0000_0000_0004; vals[1] = 64'h5555_0000_0000_0005;
    vals[2] = 64'h6666_0000_0000_0006; vals[3] = 64'h7777_0000_0000_0007;
    for (int i = 0; i < 4; i++) do_write(9'(4 + i), vals[i], 8'hFF);
    for (int i = 0; i < 4; i++) begin
      do_read(9'(4 + i), v, d);
      n_checks++;
      if (d !== vals[i]) begin n_errors++; $display("FAIL bank_iso[%0d] got %h want %h", 4 + i, d, vals[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] held;
    v_i = 1'b1; w_i = 1'b1; addr_i = 9'd8; data_i = 64'h0808_0808_0808_0808; mask_i = 8'hFF;
    @(posedge clk); #1;
    model[8] = 64'h0808_0808_0808_0808;
    w_i = 1'b0;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (Lat - 1) begin
      @(posedge clk); #1;
    end
    n_checks++; if (v_o !== 1'b1) begin n_errors++; $display("FAIL wr_rd_v got %b want 1", v_o); end
    n_checks++;
    if (data_o !== 64'h0808_0808_0808_0808) begin
      n_errors++; $display("FAIL wr_rd_data got %h want 0808080808080808", data_o);
    end
    held = 64'h0808_0808_0808_0808;
    do_write(9'd8, 64'h9999_9999_9999_9999, 8'hFF);
    repeat (Lat) begin
      @(posedge clk); #1;
    end
    n_checks++; if (v_o !== 1'b0) begin n_errors++; $display("FAIL hold_v got %b want 0", v_o); end
    n_checks++; if (data_o !== held) begin n_errors++; $display("FAIL hold_data got %h want %h", data_o, held); end
  endtask

  task automatic test_streaming();
    int   pulses = 0;
    int   j;
    logic exp_v;
    for (int c = 0; c < 16 + Lat; c++) begin
      if (c < 16) begin
        v_i = 1'b1; w_i = 1'b0; addr_i = 9'(c);
      end else begin
        v_i = 1'b0;
      end
      @(posedge clk); #1;
      j = c - (Lat - 1);
      exp_v = (j >= 0 && j < 16);
      n_checks++;
      if (v_o !== exp_v) begin n_errors++; $display("FAIL stream_v[c%0d] got %b want %b", c, v_o, exp_v); end
      if (exp_v && v_o === 1'b1) begin
        pulses++;
        n_checks++;
        if (data_o !== model[j]) begin
          n_errors++; $display("FAIL stream_data[%0d] got %h want %h", j, data_o, model[j]);
        end
      end
    end
    n_checks++; if (pulses !== 16) begin n_errors++; $display("FAIL stream_count got %0d want 16", pulses); end
  endtask

  task automatic test_mid_reset();
    logic        v;
    logic [63:0] d;
    int          cycles = 0;
    int          pulses = 0;
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd4;
    @(posedge clk); #1;
    v_i = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (v_o !== 1'b0) begin n_errors++; $display("FAIL midrst_v got %b want 0", v_o); end
    n_checks++; if (data_o !== 64'h0) begin n_errors++; $display("FAIL midrst_data got %h want 0", data_o); end
    repeat (3) begin
      @(posedge clk); #1;
      if (v_o) pulses++;
    end
    model_reset();
    reset_n = 1'b1;
    while (cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (v_o) pulses++;
      if (ready_o) break;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL midrst_no_resp got %0d pulses want 0", pulses); end
    n_checks++; if (cycles !== 128) begin n_errors++; $display("FAIL reinit_cycles got %0d want 128", cycles); end
    do_read(9'd4, v, d);
    n_checks++; if (d !== InitVal) begin n_errors++; $display("FAIL reinit_addr4 got %h want %h", d, InitVal); end
    do_read(9'd5, v, d);
    n_checks++; if (d !== InitVal) begin n_errors++; $display("FAIL reinit_addr5 got %h want %h", d, InitVal); end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_masked_write();
    test_bank_isolation();
    test_back_to_back();
    test_streaming();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
